// File: rtl/mem_ctrl_mp.sv
// Arbitrates NPORT request slots onto one byte-serial RAM bus; strobe to first beat is 2 cycles, completion is back-to-back.
// Each port holds one request: strobes are ignored while busy, and requests wait in their slot until granted.
module mem_ctrl_mp #(
    parameter int NPORT    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BUS_W    = 8,
    parameter int ARB_MODE = 0,
    parameter int RAM_LAT  = 0,
    localparam int NB      = DATA_W / BUS_W,
    localparam int LEN_W   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NPORT-1:0]       rw_flag,
    input  logic [ADDR_W*NPORT-1:0]  addr,
    input  logic [LEN_W*NPORT-1:0]   len,
    input  logic [DATA_W*NPORT-1:0]  data_in,
    output logic [DATA_W*NPORT-1:0]  data_out,
    output logic [NPORT-1:0]         busy,
    output logic [NPORT-1:0]         done,
    output logic                     ram_rw_flag,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [BUS_W-1:0]         ram_data_out,
    input  logic [BUS_W-1:0]         ram_data_in
);

    localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t                          state_q;
    logic [NPORT-1:0]                slot_vld_q, slot_rd_q;
    logic [NPORT-1:0][ADDR_W-1:0]    slot_addr_q;
    logic [NPORT-1:0][LEN_W-1:0]     slot_len_q;
    logic [NPORT-1:0][DATA_W-1:0]    slot_dat_q;
    logic [GW-1:0]                   gnt_q, gnt_d, rr_ptr_q;
    logic [LEN_W-1:0]                cnt_q, cnt_d, cap_idx;
    logic [DATA_W-1:0]               rbuf_q, rbuf_d;
    logic [DATA_W*NPORT-1:0]         data_out_q;
    logic [NPORT-1:0]                done_q, pend;
    logic                            ram_rw_q;
    logic [ADDR_W-1:0]               ram_addr_q;
    logic [BUS_W-1:0]                ram_wd_q;
    logic                            win_vld, last, cmpl, start, cap_en, cur_rd;

    always_comb begin
        cur_rd = slot_rd_q[gnt_q];
        pend   = slot_vld_q;
        if (state_q != IDLE) pend[gnt_q] = 1'b0;

        // later hits overwrite earlier ones: fixed keeps the highest index, RR the nearest after ptr
        gnt_d   = gnt_q;
        win_vld = 1'b0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NPORT; i++) begin
                if (pend[i]) begin
                    gnt_d   = GW'(i);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = NPORT; i >= 1; i--) begin
                if (pend[(int'(rr_ptr_q) + i) % NPORT]) begin
                    gnt_d   = GW'((int'(rr_ptr_q) + i) % NPORT);
                    win_vld = 1'b1;
                end
            end
        end

        last  = (state_q == XFER) && (cnt_q == slot_len_q[gnt_q]);
        cmpl  = (state_q == DRAIN) || (last && !(RAM_LAT == 1 && cur_rd));
        start = win_vld && ((state_q == IDLE) || cmpl);
        cnt_d = cnt_q + LEN_W'(1);

        // with a registered RAM the read data trails the address by one beat
        cap_en  = cur_rd && ((RAM_LAT == 0) ? (state_q == XFER)
                                            : ((state_q == DRAIN) || (state_q == XFER && cnt_q != '0)));
        cap_idx = (RAM_LAT == 0 || state_q == DRAIN) ? cnt_q : cnt_q - LEN_W'(1);
        rbuf_d  = rbuf_q;
        if (cap_en) rbuf_d[int'(cap_idx)*BUS_W +: BUS_W] = ram_data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_vld_q  <= '0;
            slot_rd_q   <= '0;
            slot_addr_q <= '0;
            slot_len_q  <= '0;
            slot_dat_q  <= '0;
            gnt_q       <= '0;
            rr_ptr_q    <= GW'(NPORT - 1);
            cnt_q       <= '0;
            rbuf_q      <= '0;
            data_out_q  <= '0;
            done_q      <= '0;
            ram_rw_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wd_q    <= '0;
        end else begin
            done_q <= '0;
            rbuf_q <= rbuf_d;

            for (int p = 0; p < NPORT; p++) begin
                if (rw_flag[2*p +: 2] != 2'b00 && !slot_vld_q[p]) begin
                    slot_vld_q[p]  <= 1'b1;
                    slot_rd_q[p]   <= rw_flag[2*p+1];
                    slot_addr_q[p] <= addr[p*ADDR_W +: ADDR_W];
                    slot_len_q[p]  <= len[p*LEN_W +: LEN_W];
                    slot_dat_q[p]  <= data_in[p*DATA_W +: DATA_W];
                end
            end

            if (cmpl) begin
                slot_vld_q[gnt_q] <= 1'b0;
                done_q[gnt_q]     <= 1'b1;
                if (cur_rd) data_out_q[int'(gnt_q)*DATA_W +: DATA_W] <= rbuf_d;
                state_q           <= IDLE;
                ram_rw_q          <= 1'b1;
            end else if (state_q == XFER) begin
                if (last) begin
                    state_q <= DRAIN;
                end else begin
                    cnt_q      <= cnt_d;
                    ram_addr_q <= ram_addr_q + ADDR_W'(1);
                    ram_wd_q   <= cur_rd ? '0 : slot_dat_q[gnt_q][int'(cnt_d)*BUS_W +: BUS_W];
                end
            end

            // a grant overrides the completion's return to IDLE, giving back-to-back service
            if (start) begin
                state_q    <= XFER;
                gnt_q      <= gnt_d;
                rr_ptr_q   <= gnt_d;
                cnt_q      <= '0;
                rbuf_q     <= '0;
                ram_rw_q   <= slot_rd_q[gnt_d];
                ram_addr_q <= slot_addr_q[gnt_d];
                ram_wd_q   <= slot_rd_q[gnt_d] ? '0 : slot_dat_q[gnt_d][BUS_W-1:0];
            end
        end
    end

    assign busy         = slot_vld_q;
    assign done         = done_q;
    assign data_out     = data_out_q;
    assign ram_rw_flag  = ram_rw_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_out = ram_wd_q;

endmodule
